// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory requests, aligns load data
// and drives the registered MEM/WB and trap outputs.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic [31:0] i_result,
    input  logic [31:0] i_data_store,
    input  logic [31:0] i_pc,
    input  logic [2:0]  i_func3,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_rdy,
    input  logic        i_dmem_rvld,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_vld,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_wb_pc,
    output logic        o_trap,
    output logic [3:0]  o_trap_cause,
    output logic [31:0] o_trap_pc
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;

    logic        is_load_s;
    logic        is_store_s;
    logic        mem_op_s;
    logic        f3_ok_s;
    logic        misal_s;
    logic        trap_s;
    logic        legal_s;
    logic [3:0]  cause_s;
    logic        retire_s;
    logic        wb_en_s;
    logic [31:0] wb_data_s;
    logic        trap_fire_s;
    logic        capture_s;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] strb;
        case (f3)
            3'd0:    strb = 4'b0001 << lo;
            3'd1:    strb = 4'b0011 << {lo[1], 1'b0};
            3'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            3'd0:    w = {4{d[7:0]}};
            3'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd4:    r = {24'd0, sh[7:0]};
            3'd5:    r = {16'd0, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Decode legality and alignment of the presented memory op.
    always_comb begin
        is_load_s  = (i_opcode == OP_LOAD);
        is_store_s = (i_opcode == OP_STORE);
        mem_op_s   = i_vld & (is_load_s | is_store_s);
        f3_ok_s    = 1'b0;
        if (is_load_s) begin
            case (i_func3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok_s = 1'b1;
                default:                      f3_ok_s = 1'b0;
            endcase
        end else begin
            f3_ok_s = (i_func3 <= 3'd2);
        end
        misal_s = ((i_func3[1:0] == 2'b01) & i_result[0]) |
                  ((i_func3[1:0] == 2'b10) & (i_result[1:0] != 2'b00));
        trap_s  = mem_op_s & (~f3_ok_s | misal_s);
        legal_s = mem_op_s & ~trap_s;
        if (!f3_ok_s) begin
            cause_s = 4'd2;
        end else if (is_load_s) begin
            cause_s = 4'd4;
        end else begin
            cause_s = 4'd6;
        end
    end

    // Next-state, retire and write-back selection.
    always_comb begin
        state_d     = state_q;
        retire_s    = 1'b0;
        wb_en_s     = 1'b0;
        wb_data_s   = i_result;
        trap_fire_s = 1'b0;
        capture_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_vld && !mem_op_s) begin
                    retire_s = 1'b1;
                    wb_en_s  = (i_rd != 5'd0) && (i_opcode != OP_BRANCH);
                end else if (trap_s) begin
                    retire_s    = 1'b1;
                    trap_fire_s = 1'b1;
                end else if (legal_s) begin
                    if (i_dmem_rdy) begin
                        capture_s = 1'b1;
                        if (is_store_s) begin
                            retire_s = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_dmem_rdy) begin
                    capture_s = 1'b1;
                    if (is_store_s) begin
                        retire_s = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvld) begin
                    retire_s  = 1'b1;
                    wb_en_s   = (i_rd != 5'd0);
                    wb_data_s = load_align(f3_q, lane_q, i_dmem_rdata);
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request port; fields come straight from the held execute-stage inputs.
    always_comb begin
        o_dmem_req   = rst_n & (((state_q == ST_IDLE) & legal_s) | (state_q == ST_REQ));
        o_dmem_we    = is_store_s;
        o_dmem_addr  = {i_result[31:2], 2'b00};
        o_dmem_wdata = is_store_s ? store_data(i_func3, i_data_store) : 32'd0;
        o_dmem_wstrb = is_store_s ? store_strb(i_func3, i_result[1:0]) : 4'b0000;
        o_stall      = i_vld & ~retire_s;
    end

    // FSM state, accepted-request capture and registered MEM/WB outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lane_q       <= 2'd0;
            f3_q         <= 3'd0;
            o_wb_vld     <= 1'b0;
            o_wb_en      <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= 32'd0;
            o_wb_pc      <= RESET_PC;
            o_trap       <= 1'b0;
            o_trap_cause <= 4'd0;
            o_trap_pc    <= RESET_PC;
        end else begin
            state_q  <= state_d;
            o_wb_vld <= retire_s;
            o_wb_en  <= retire_s & wb_en_s;
            o_trap   <= trap_fire_s;
            if (capture_s) begin
                lane_q <= i_result[1:0];
                f3_q   <= i_func3;
            end
            if (retire_s) begin
                o_wb_rd   <= i_rd;
                o_wb_data <= wb_data_s;
                o_wb_pc   <= i_pc;
            end
            if (trap_fire_s) begin
                o_trap_cause <= cause_s;
                o_trap_pc    <= i_pc;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a retire-queue reference model.
module tb_mem_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [6:0]  OP_LD  = 7'b0000011;
    localparam logic [6:0]  OP_ST  = 7'b0100011;
    localparam logic [6:0]  OP_ALU = 7'b0110011;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_vld = 1'b0;
    logic [31:0] i_result = 32'd0;
    logic [31:0] i_data_store = 32'd0;
    logic [31:0] i_pc = 32'd0;
    logic [2:0]  i_func3 = 3'd0;
    logic [6:0]  i_opcode = 7'd0;
    logic [4:0]  i_rd = 5'd0;
    logic        i_dmem_rdy = 1'b0;
    logic        i_dmem_rvld = 1'b0;
    logic [31:0] i_dmem_rdata = 32'd0;
    logic        o_stall, o_dmem_req, o_dmem_we, o_wb_vld, o_wb_en, o_trap;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data, o_wb_pc, o_trap_pc;
    logic [3:0]  o_dmem_wstrb, o_trap_cause;
    logic [4:0]  o_wb_rd;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [3:0]  last_wstrb = 4'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        en;
        logic        trap;
        logic [3:0]  cause;
        logic        chk_data;
        logic        is_mem;
        logic        is_load;
    } exp_t;

    exp_t exp_q[$];

    mem_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_result(i_result),
        .i_data_store(i_data_store), .i_pc(i_pc), .i_func3(i_func3),
        .i_opcode(i_opcode), .i_rd(i_rd), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_rdy(i_dmem_rdy), .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_vld(o_wb_vld), .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_wb_pc(o_wb_pc), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_trap_pc(o_trap_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // What one instruction must produce when it retires.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] res, input logic [31:0] rdata,
                                   input logic [31:0] pc, input logic [4:0] rd);
        exp_t e;
        int size;
        logic legal;
        logic [31:0] w;
        e = '0;
        e.rd = rd; e.pc = pc; e.data = res; e.chk_data = 1'b1;
        e.is_load = (op == OP_LD);
        e.is_mem  = e.is_load || (op == OP_ST);
        if (!e.is_mem) begin
            e.en = (rd != 5'd0) && (op != OP_BR);
        end else begin
            legal = e.is_load ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2);
            size = 1 << f3[1:0];
            if (!legal) begin
                e.trap = 1'b1; e.cause = 4'd2;
            end else if ((res & 32'(size - 1)) != 32'd0) begin
                e.trap = 1'b1; e.cause = e.is_load ? 4'd4 : 4'd6;
            end
            if (e.trap || !e.is_load) begin
                e.chk_data = 1'b0;
            end else begin
                w = rdata >> (8 * res[1:0]);
                if (size == 1) begin
                    e.data = w & 32'h0000_00FF;
                    if (f3 == 3'd0 && w[7]) e.data = e.data | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    e.data = w & 32'h0000_FFFF;
                    if (f3 == 3'd1 && w[15]) e.data = e.data | 32'hFFFF_0000;
                end else begin
                    e.data = rdata;
                end
                e.en = (rd != 5'd0);
            end
        end
        return e;
    endfunction

    // Every retirement is checked against the oldest predicted instruction.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (rst_n) begin
            if (o_wb_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'(o_wb_vld), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_rd", 32'(o_wb_rd), 32'(e.rd));
                    check("wb_en", 32'(o_wb_en), 32'(e.en));
                    check("wb_pc", o_wb_pc, e.pc);
                    check("trap", 32'(o_trap), 32'(e.trap));
                    if (e.trap) begin
                        check("trap_cause", 32'(o_trap_cause), 32'(e.cause));
                        check("trap_pc", o_trap_pc, e.pc);
                    end
                    if (e.chk_data) check("wb_data", o_wb_data, e.data);
                end
            end else begin
                check("idle_quiet", {30'd0, o_wb_en, o_trap}, 32'd0);
            end
        end
    end

    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd,
                         input int rdy_dly, input int rvld_dly, input logic [31:0] rdata);
        exp_t e;
        int cyc, acc_cyc, stalls, exp_stalls, size;
        bit accepted, done, legal_mem;
        logic [31:0] ew;
        logic [3:0]  es;
        e = model(op, f3, res, rdata, pc, rd);
        legal_mem  = e.is_mem && !e.trap;
        exp_stalls = legal_mem ? rdy_dly + (e.is_load ? 1 + rvld_dly : 0) : 0;
        size = 1 << f3[1:0];
        ew = (size == 1) ? sd[7:0] * 32'h0101_0101 : (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
        es = 4'(((1 << size) - 1) << res[1:0]);
        exp_q.push_back(e);
        i_vld = 1'b1; i_opcode = op; i_func3 = f3; i_result = res; i_data_store = sd;
        i_pc = pc; i_rd = rd; i_dmem_rdata = rdata;
        i_dmem_rdy = (rdy_dly == 0); i_dmem_rvld = 1'b0;
        cyc = 0; acc_cyc = 0; stalls = 0; accepted = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            check("dmem_req", 32'(o_dmem_req), 32'(legal_mem && !accepted));
            if (o_dmem_req) begin
                check("dmem_we", 32'(o_dmem_we), 32'(op == OP_ST));
                check("dmem_addr", o_dmem_addr, res & 32'hFFFF_FFFC);
                if (op == OP_ST) begin
                    check("dmem_wdata", o_dmem_wdata, ew);
                    check("dmem_wstrb", 32'(o_dmem_wstrb), 32'(es));
                end else begin
                    check("dmem_wstrb_ld", 32'(o_dmem_wstrb), 32'd0);
                end
                last_wdata = o_dmem_wdata; last_wstrb = o_dmem_wstrb;
            end
            if (o_dmem_req && i_dmem_rdy) begin
                accepted = 1; acc_cyc = cyc;
            end
            if (o_stall) stalls++; else done = 1;
            @(posedge clk); #1;
            if (!done) begin
                cyc++;
                if (cyc > 40) begin
                    check("timeout", 32'(cyc), 32'd40);
                    done = 1;
                end
                i_dmem_rdy  = !accepted && (cyc >= rdy_dly);
                i_dmem_rvld = accepted && e.is_load && (cyc == acc_cyc + 1 + rvld_dly);
            end
        end
        i_vld = 1'b0; i_dmem_rdy = 1'b0; i_dmem_rvld = 1'b0;
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("wb_vld_latency", 32'(o_wb_vld), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_wb_vld", 32'(o_wb_vld), 32'd0);
        check("rst_wb_en", 32'(o_wb_en), 32'd0);
        check("rst_wb_rd", 32'(o_wb_rd), 32'd0);
        check("rst_wb_data", o_wb_data, 32'd0);
        check("rst_wb_pc", o_wb_pc, RST_PC);
        check("rst_trap", 32'(o_trap), 32'd0);
        check("rst_trap_cause", 32'(o_trap_cause), 32'd0);
        check("rst_trap_pc", o_trap_pc, RST_PC);
        check("rst_dmem_req", 32'(o_dmem_req), 32'd0);
    endtask

    initial begin
        #12;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_ALU, 3'd0, 32'h15, 32'd0, 32'h200, 5'd4, 0, 0, 32'd0);
        check("lit_add_data", o_wb_data, 32'h15);
        check("lit_add_en", 32'(o_wb_en), 32'd1);
        check("lit_add_rd", 32'(o_wb_rd), 32'd4);
        do_op(OP_IMM, 3'd0, 32'h0, 32'd0, 32'h204, 5'd0, 0, 0, 32'd0);
        check("lit_nop_en", 32'(o_wb_en), 32'd0);
        do_op(OP_BR, 3'd0, 32'h44, 32'd0, 32'h208, 5'd5, 0, 0, 32'd0);
        do_op(OP_ST, 3'd0, 32'h1002, 32'hA5, 32'h20C, 5'd0, 0, 0, 32'd0);
        check("lit_sb_wdata", last_wdata, 32'hA5A5_A5A5);
        check("lit_sb_wstrb", 32'(last_wstrb), 32'h4);
        do_op(OP_LD, 3'd0, 32'h1002, 32'd0, 32'h210, 5'd6, 2, 0, 32'h0080_0000);
        check("lit_lb_data", o_wb_data, 32'hFFFF_FF80);
        do_op(OP_LD, 3'd4, 32'h1002, 32'd0, 32'h214, 5'd6, 2, 0, 32'h0080_0000);
        check("lit_lbu_data", o_wb_data, 32'h0000_0080);
        do_op(OP_LD, 3'd2, 32'h1001, 32'd0, 32'h218, 5'd7, 0, 0, 32'd0);
        check("lit_lw_mis_cause", 32'(o_trap_cause), 32'd4);
        check("lit_lw_mis_pc", o_trap_pc, 32'h218);
        do_op(OP_ST, 3'd1, 32'h1003, 32'h55, 32'h21C, 5'd0, 0, 0, 32'd0);
        check("lit_sh_mis_cause", 32'(o_trap_cause), 32'd6);
        do_op(OP_LD, 3'd3, 32'h1000, 32'd0, 32'h220, 5'd8, 0, 0, 32'd0);
        check("lit_ld_f3_cause", 32'(o_trap_cause), 32'd2);
        do_op(OP_LD, 3'd1, 32'h1006, 32'd0, 32'h224, 5'd9, 0, 1, 32'h8001_0000);
        check("lit_lh_data", o_wb_data, 32'hFFFF_8001);
        do_op(OP_LD, 3'd5, 32'h1006, 32'd0, 32'h228, 5'd9, 0, 0, 32'h8001_0000);
        do_op(OP_ST, 3'd2, 32'h2000, 32'hDEAD_BEEF, 32'h22C, 5'd0, 1, 0, 32'd0);
        do_op(OP_ST, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h230, 5'd0, 0, 0, 32'd0);
        check("lit_sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("lit_sh_wstrb", 32'(last_wstrb), 32'hC);
        do_op(OP_LD, 3'd2, 32'h2004, 32'd0, 32'h234, 5'd10, 1, 2, 32'h1234_5678);
        do_op(OP_LD, 3'd0, 32'h2001, 32'd0, 32'h238, 5'd0, 0, 0, 32'h0000_7F00);
        do_op(OP_ST, 3'd3, 32'h2000, 32'd1, 32'h23C, 5'd0, 0, 0, 32'd0);
        do_op(OP_ALU, 3'd0, 32'hCAFE_0001, 32'd0, 32'h240, 5'd31, 0, 0, 32'd0);

        // Reset while the load waits for data; the late rvld must be ignored.
        i_vld = 1'b1; i_opcode = OP_LD; i_func3 = 3'd2; i_result = 32'h3000;
        i_pc = 32'h244; i_rd = 5'd11; i_dmem_rdy = 1'b1; i_dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("rw_req", 32'(o_dmem_req), 32'd1);
        @(posedge clk); #1;
        i_dmem_rdy = 1'b0;
        @(negedge clk);
        check("rw_wait_stall", 32'(o_stall), 32'd1);
        check("rw_wait_noreq", 32'(o_dmem_req), 32'd0);
        #1 rst_n = 1'b0; i_vld = 1'b0;
        #1 check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1; i_dmem_rvld = 1'b1;
        @(negedge clk);
        check("rw_rvld_nostall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        i_dmem_rvld = 1'b0;
        check("rw_no_retire", 32'(o_wb_vld), 32'd0);
        check("rw_pc_kept", o_wb_pc, RST_PC);
        do_op(OP_ALU, 3'd0, 32'h77, 32'd0, 32'h248, 5'd12, 0, 0, 32'd0);

        repeat (3) @(posedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
